logic_arbiter: RTL

LOGIC_ARBITER -- requirements
Module: logic_arbiter

---
 rtl/logic_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/logic_arbiter.sv
// Two-requester round-robin front end for a shared combinational logic unit.
// Results are registered, so no combinational path runs from requester inputs to res_*.
module logic_arbiter #(
  parameter int OPD_LENGTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req1_valid,
  output logic                  req0_ready,
  output logic                  req1_ready,
  input  logic [OPD_LENGTH-1:0] req0_opd1,
  input  logic [OPD_LENGTH-1:0] req0_opd2,
  input  logic [3:0]            req0_op,
  input  logic [OPD_LENGTH-1:0] req1_opd1,
  input  logic [OPD_LENGTH-1:0] req1_opd2,
  input  logic [3:0]            req1_op,
  output logic [OPD_LENGTH-1:0] lu_opd1,
  output logic [OPD_LENGTH-1:0] lu_opd2,
  output logic [3:0]            lu_op,
  input  logic [OPD_LENGTH-1:0] lu_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [OPD_LENGTH-1:0] res_data,
  output logic                  res_id,
  output logic                  res_err,
  output logic [15:0]           op_count
);

  logic prio_r;
  logic sel_s;
  logic sel_valid_s;
  logic slot_free_s;
  logic accept_s;

  // Only the low three op bits select the function; bit 3 is ignored.
  function automatic logic op_is_valid(input logic [2:0] op);
    case (op)
      3'b111, 3'b110, 3'b100, 3'b000, 3'b001: op_is_valid = 1'b1;
      default:                                op_is_valid = 1'b0;
    endcase
  endfunction

  // Requester selection: a lone requester wins, otherwise the priority pointer decides.
  always_comb begin
    sel_s = prio_r;
    case ({req1_valid, req0_valid})
      2'b01:   sel_s = 1'b0;
      2'b10:   sel_s = 1'b1;
      default: sel_s = prio_r;
    endcase
  end

  // Steer the selected requester onto the shared logic unit.
  always_comb begin
    lu_opd1 = req0_opd1;
    lu_opd2 = req0_opd2;
    lu_op   = req0_op;
    if (sel_s) begin
      lu_opd1 = req1_opd1;
      lu_opd2 = req1_opd2;
      lu_op   = req1_op;
    end else begin
      lu_opd1 = req0_opd1;
      lu_opd2 = req0_opd2;
      lu_op   = req0_op;
    end
  end

  assign sel_valid_s = sel_s ? req1_valid : req0_valid;
  assign slot_free_s = !res_valid || res_ready;
  // Ready is gated by rst_n so nothing is granted while reset is asserted.
  assign req0_ready  = rst_n && !sel_s && req0_valid && slot_free_s;
  assign req1_ready  = rst_n &&  sel_s && req1_valid && slot_free_s;
  assign accept_s    = req0_ready || req1_ready;

  // Result register, priority pointer and accepted-operation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= {OPD_LENGTH{1'b0}};
      res_id    <= 1'b0;
      res_err   <= 1'b0;
      prio_r    <= 1'b0;
      op_count  <= 16'd0;
    end else if (accept_s) begin
      res_valid <= 1'b1;
      res_id    <= sel_s;
      prio_r    <= !sel_s;
      op_count  <= op_count + 16'd1;
      if (op_is_valid(lu_op[2:0])) begin
        res_data <= lu_result;
        res_err  <= 1'b0;
      end else begin
        res_data <= {OPD_LENGTH{1'b0}};
        res_err  <= 1'b1;
      end
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule
